// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the 2-bit saturating-counter branch predictor:
// counter state encodings, reset default and the saturating step function.
package branch_predictor_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,  // strongly not taken
    WNT = 2'b01,  // weakly not taken
    WT  = 2'b10,  // weakly taken
    ST  = 2'b11   // strongly taken
  } state_e;

  localparam logic [1:0] DEFAULT_INIT_STATE = WT;

  // One step toward the resolved outcome, holding at either end.
  function automatic state_e next_state(input state_e state, input logic taken);
    state_e nxt;
    nxt = state;
    unique case (state)
      SNT: nxt = taken ? WNT : SNT;
      WNT: nxt = taken ? WT  : SNT;
      WT:  nxt = taken ? ST  : WNT;
      ST:  nxt = taken ? ST  : WT;
      default: nxt = state;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// Single 2-bit saturating counter with enable and a configurable async reset value.
module sat_counter2
  import branch_predictor_pkg::*;
#(
  parameter logic [1:0] RST_VAL = DEFAULT_INIT_STATE
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       taken,
  output logic [1:0] state
);

  state_e state_q;

  // NOTE: sequential state uses non-blocking assignments so every counter
  // samples the pre-edge values of its neighbours and of the shared inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= state_e'(RST_VAL);
    end else if (en) begin
      state_q <= next_state(state_q, taken);
    end
  end

  assign state = state_q;

endmodule

// File: rtl/branch_predictor.sv
// Untagged table of 2-bit saturating counters: predicts the ID branch, trains
// on resolved EX branches and keeps saturating branch/mispredict statistics.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int         INDEX_W    = 4,
  parameter logic [1:0] INIT_STATE = DEFAULT_INIT_STATE,
  parameter int         CNT_W      = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [31:0]      ID_pc_i,
  input  logic             EX_Branch_i,
  input  logic             EX_Zero_i,
  input  logic             EX_Predict_i,
  input  logic [31:0]      EX_pc_i,
  input  logic             hold_i,
  output logic             Predict_o,
  output logic [CNT_W-1:0] branch_count_o,
  output logic [CNT_W-1:0] mispredict_count_o
);

  localparam int ENTRIES = 2 ** INDEX_W;

  logic [INDEX_W-1:0] lookup_idx;
  logic [INDEX_W-1:0] update_idx;
  logic               upd;
  logic               mispredict;
  logic [1:0]         cnt_table [ENTRIES];

  assign lookup_idx = ID_pc_i[INDEX_W+1:2];
  assign update_idx = EX_pc_i[INDEX_W+1:2];
  assign upd        = EX_Branch_i && !hold_i;
  assign mispredict = EX_Predict_i ^ EX_Zero_i;

  // Word-offset bits and bits above the index play no part in the lookup.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{ID_pc_i[31:INDEX_W+2], ID_pc_i[1:0],
                            EX_pc_i[31:INDEX_W+2], EX_pc_i[1:0]};

  // NOTE: the table is built from individually reset flops rather than a RAM,
  // because every entry must snap to INIT_STATE asynchronously on reset.
  for (genvar i = 0; i < ENTRIES; i++) begin : g_entry
    sat_counter2 #(
      .RST_VAL(INIT_STATE)
    ) u_cnt (
      .clk  (clk_i),
      .rst_n(rst_i),
      .en   (upd && (update_idx == INDEX_W'(i))),
      .taken(EX_Zero_i),
      .state(cnt_table[i])
    );
  end

  // Read of registered state only: a same-cycle update is seen next cycle.
  assign Predict_o = cnt_table[lookup_idx][1];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      branch_count_o     <= '0;
      mispredict_count_o <= '0;
    end else if (upd) begin
      if (branch_count_o != '1) begin
        branch_count_o <= branch_count_o + CNT_W'(1);
      end
      if (mispredict && (mispredict_count_o != '1)) begin
        mispredict_count_o <= mispredict_count_o + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed vector table, hand-written
// corner sequences and randomized traffic against an array-based reference model.
`timescale 1ns/1ps
module tb_branch_predictor;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] ID_pc_i;
  logic        EX_Branch_i;
  logic        EX_Zero_i;
  logic        EX_Predict_i;
  logic [31:0] EX_pc_i;
  logic        hold_i;
  logic        Predict_o;
  logic [31:0] branch_count_o;
  logic [31:0] mispredict_count_o;

  int n_pass  = 0;
  int n_total = 0;

  branch_predictor dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .ID_pc_i           (ID_pc_i),
    .EX_Branch_i       (EX_Branch_i),
    .EX_Zero_i         (EX_Zero_i),
    .EX_Predict_i      (EX_Predict_i),
    .EX_pc_i           (EX_pc_i),
    .hold_i            (hold_i),
    .Predict_o         (Predict_o),
    .branch_count_o    (branch_count_o),
    .mispredict_count_o(mispredict_count_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] id_pc;
    logic [31:0] ex_pc;
    logic        br;
    logic        zero;
    logic        pred_in;
    logic        hold;
    logic        exp_pred;   // Predict_o before the edge
    int          exp_bc;     // counts after the edge
    int          exp_mc;
  } vec_t;

  vec_t vecs[$];

  // Reference model: counter value per entry as a plain integer 0..3.
  int model_cnt [16];
  int model_bc;
  int model_mc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic [31:0] id_pc, input logic [31:0] ex_pc,
                       input logic br, input logic zero, input logic pred_in,
                       input logic hold);
    ID_pc_i = id_pc; EX_pc_i = ex_pc; EX_Branch_i = br;
    EX_Zero_i = zero; EX_Predict_i = pred_in; hold_i = hold;
  endtask

  task automatic do_reset();
    drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_i = 1'b0;
    #3;
    rst_i = 1'b1;
    step();
    for (int i = 0; i < 16; i++) model_cnt[i] = 2;
    model_bc = 0;
    model_mc = 0;
  endtask

  task automatic model_update(input logic [31:0] ex_pc, input logic br,
                              input logic zero, input logic pred_in, input logic hold);
    int idx;
    idx = int'(ex_pc[5:2]);
    if (br && !hold) begin
      if (zero) model_cnt[idx] = (model_cnt[idx] < 3) ? model_cnt[idx] + 1 : 3;
      else      model_cnt[idx] = (model_cnt[idx] > 0) ? model_cnt[idx] - 1 : 0;
      model_bc++;
      if (pred_in != zero) model_mc++;
    end
  endtask

  initial begin
    // Directed vectors, starting from a fresh reset.
    // Saturation toward taken then back down on entry 2.
    vecs.push_back('{32'h08, 32'h08, 1, 1, 1, 0, 1, 1, 0});
    vecs.push_back('{32'h08, 32'h08, 1, 1, 1, 0, 1, 2, 0});
    vecs.push_back('{32'h08, 32'h08, 1, 1, 1, 0, 1, 3, 0});
    vecs.push_back('{32'h08, 32'h08, 1, 0, 1, 0, 1, 4, 1});
    vecs.push_back('{32'h08, 32'h08, 1, 0, 1, 0, 1, 5, 2});
    vecs.push_back('{32'h08, 32'h08, 0, 1, 0, 0, 0, 5, 2});
    // Mispredict counting on entry 4: (pred,zero) = (1,0),(0,0),(0,1),(1,1).
    vecs.push_back('{32'h10, 32'h10, 1, 0, 1, 0, 1, 6, 3});
    vecs.push_back('{32'h10, 32'h10, 1, 0, 0, 0, 0, 7, 3});
    vecs.push_back('{32'h10, 32'h10, 1, 1, 0, 0, 0, 8, 4});
    vecs.push_back('{32'h10, 32'h10, 1, 1, 1, 0, 0, 9, 4});
    vecs.push_back('{32'h10, 32'h10, 0, 0, 1, 0, 1, 9, 4});
    // Hold on entry 8 for three cycles, then one real update.
    vecs.push_back('{32'h20, 32'h20, 1, 0, 1, 1, 1, 9, 4});
    vecs.push_back('{32'h20, 32'h20, 1, 0, 1, 1, 1, 9, 4});
    vecs.push_back('{32'h20, 32'h20, 1, 0, 1, 1, 1, 9, 4});
    vecs.push_back('{32'h20, 32'h20, 1, 0, 1, 0, 1, 10, 5});
    vecs.push_back('{32'h20, 32'h20, 0, 1, 0, 0, 0, 10, 5});

    rst_i = 1'b1;
    drive(32'h40, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    rst_i = 1'b0;
    #1;
    check("predict_in_reset", 32'(Predict_o), 32'd1);
    #2;
    rst_i = 1'b1;
    step();
    check("reset_predict", 32'(Predict_o), 32'd1);
    check("reset_branch_count", branch_count_o, 32'd0);
    check("reset_mispredict_count", mispredict_count_o, 32'd0);

    foreach (vecs[k]) begin
      drive(vecs[k].id_pc, vecs[k].ex_pc, vecs[k].br, vecs[k].zero,
            vecs[k].pred_in, vecs[k].hold);
      #1;
      check($sformatf("vec%0d_predict", k), 32'(Predict_o), 32'(vecs[k].exp_pred));
      step();
      check($sformatf("vec%0d_branch_count", k), branch_count_o, 32'(vecs[k].exp_bc));
      check($sformatf("vec%0d_mispredict_count", k), mispredict_count_o, 32'(vecs[k].exp_mc));
    end

    // Same-cycle lookup/update of idx 1 (still WT), then an aliasing lookup.
    drive(32'h44, 32'h44, 1'b1, 1'b0, 1'b1, 1'b0);
    #1;
    check("same_cycle_pre_update", 32'(Predict_o), 32'd1);
    step();
    EX_Branch_i = 1'b0;
    #1;
    check("same_cycle_next", 32'(Predict_o), 32'd0);
    ID_pc_i = 32'h04;
    #1;
    check("alias_idx1", 32'(Predict_o), 32'd0);

    // Randomized traffic against the reference model.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      logic [31:0] id_pc, ex_pc;
      logic br, zero, pin, hold;
      id_pc = $urandom;
      ex_pc = (n % 3 == 0) ? id_pc : $urandom;
      br    = ($urandom_range(0, 3) != 0);
      zero  = $urandom_range(0, 1) != 0;
      pin   = $urandom_range(0, 1) != 0;
      hold  = ($urandom_range(0, 4) == 0);
      drive(id_pc, ex_pc, br, zero, pin, hold);
      #1;
      check("rand_predict", 32'(Predict_o), 32'(model_cnt[int'(id_pc[5:2])] >= 2));
      model_update(ex_pc, br, zero, pin, hold);
      step();
      check("rand_branch_count", branch_count_o, 32'(model_bc));
      check("rand_mispredict_count", mispredict_count_o, 32'(model_mc));
    end
    check("rand_counts_nonzero", 32'(branch_count_o != 0), 32'd1);

    // Train a few entries strongly taken, then pulse reset between edges.
    for (int i = 0; i < 4; i++) begin
      drive(32'(i * 4), 32'(i * 4), 1'b1, 1'b1, 1'b0, 1'b0);
      step();
      step();
    end
    drive(32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    #2;
    rst_i = 1'b0;
    #0.5;
    check("async_rst_branch_count", branch_count_o, 32'd0);
    check("async_rst_mispredict_count", mispredict_count_o, 32'd0);
    check("async_rst_predict", 32'(Predict_o), 32'd1);
    #0.5;
    rst_i = 1'b1;
    EX_Branch_i = 1'b0;
    #0.5;
    check("after_rst_branch_count", branch_count_o, 32'd0);
    step();

    // Every entry must be WT: one not-taken step takes it to predict 0.
    for (int i = 0; i < 16; i++) begin
      drive(32'(i * 4), 32'(i * 4), 1'b1, 1'b0, 1'b0, 1'b0);
      #1;
      check($sformatf("entry%0d_pre", i), 32'(Predict_o), 32'd1);
      step();
      EX_Branch_i = 1'b0;
      #1;
      check($sformatf("entry%0d_post", i), 32'(Predict_o), 32'd0);
    end
    check("post_reset_branch_count", branch_count_o, 32'd16);
    check("post_reset_mispredict_count", mispredict_count_o, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Table of 2-bit saturating counters that supplies the taken/not-taken prediction for the branch currently in ID.
- Trains on resolved branch outcomes from EX, so the branch handler's prediction input and its EX-stage outcome now come from one block.
- Keeps branch and mispredict statistics for lab reporting.
- Sits beside the branch handler: prediction drives the handler's prediction input; EX-stage branch signals feed back here.

Parameters:
- INDEX_W, 4, table index width; table holds 2**INDEX_W entries.
- INIT_STATE, 2'b10, counter value loaded into every entry at reset (weakly taken).
- CNT_W, 32, width of each statistics counter.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  asynchronous, active-low reset.
- ID_pc_i  input  32  PC of the instruction in ID; lookup address.
- EX_Branch_i  input  1  instruction in EX is a conditional branch.
- EX_Zero_i  input  1  resolved outcome of the EX branch; 1 = taken.
- EX_Predict_i  input  1  prediction carried down the pipe with the EX branch.
- EX_pc_i  input  32  PC of the instruction in EX; update address.
- hold_i  input  1  pipeline stall; suppresses training and statistics for the cycle.
- Predict_o  output  1  prediction for the ID instruction; 1 = taken.
- branch_count_o  output  CNT_W  number of resolved branches.
- mispredict_count_o  output  CNT_W  number of resolved branches whose prediction was wrong.

Behaviour:
- Indexing: lookup idx = ID_pc_i[INDEX_W+1:2]; update idx = EX_pc_i[INDEX_W+1:2]. PC bits [1:0] are ignored. No tags: aliasing branches share an entry.
- Prediction:
  - Predict_o = table[lookup idx][1], combinational from registered state; zero-cycle latency.
  - Predict_o is valid regardless of whether ID holds a branch; the branch handler qualifies it.
- Update condition: upd = EX_Branch_i && !hold_i.
- Training: when upd, at the rising edge table[update idx] moves one step toward the outcome.
  - Taken: 00→01→10→11, saturates at 11.
  - Not taken: 11→10→01→00, saturates at 00.
  - Exactly one entry changes per cycle at most.
- States, named in the shared package:
  - SNT = 00, strongly not taken
  - WNT = 01, weakly not taken
  - WT = 10, weakly taken
  - ST = 11, strongly taken
- Same-cycle lookup and update of the same index: Predict_o reflects the pre-update value (no bypass). The new value is visible from the next cycle.
- Statistics:
  - When upd, branch_count_o increments by 1.
  - When upd and (EX_Predict_i ^ EX_Zero_i), mispredict_count_o increments by 1.
  - Both counters saturate at all-ones and never wrap.
  - mispredict_count_o <= branch_count_o always holds.
- hold_i = 1 with EX_Branch_i = 1: no table change and no count change. The same branch is counted once, on the cycle hold_i drops.
- Reset:
  - rst_i low immediately forces every entry to INIT_STATE and both counters to 0, independent of clk_i.
  - Predict_o therefore reads INIT_STATE[1] (1 at default) during reset.
  - Reset asserted mid-training discards the pending update.
- X-safety: EX_Zero_i and EX_Predict_i are don't-care when EX_Branch_i = 0 and must not affect state.

Decomposition:
- Shared package holds:
  - 2-bit counter state encodings SNT/WNT/WT/ST
  - default INIT_STATE
  - helper function next_state(state, taken) implementing saturation
- One natural sub-module, sat_counter2: a single 2-bit saturating counter with enable, taken, async active-low reset and reset value. It is instantiated 2**INDEX_W times via generate.
- Statistics counters stay in the top module.

Test Plan:
- Reset value: release rst_i, ID_pc_i=0x00000040 → Predict_o=1; both counts 0.
- Saturation toward taken: EX_pc_i=0x00000008, EX_Branch_i=1, EX_Zero_i=1 for 3 cycles → entry 2 goes 10→11→11→11. Then EX_Zero_i=0 for 2 cycles → 11→10→01, and Predict_o at ID_pc_i=0x08 = 0. branch_count_o=5.
- Mispredict counting: 4 branches with (EX_Predict_i, EX_Zero_i) = (1,0), (0,0), (0,1), (1,1) → branch_count_o=4, mispredict_count_o=2.
- Aliasing and same-cycle update:
  - ID_pc_i = EX_pc_i = 0x00000044 (idx 1, state 10), not-taken update → Predict_o=1 that cycle, 0 the next.
  - Then ID_pc_i=0x00000004 (aliases idx 1) → Predict_o=0.
- Hold: hold_i=1, EX_Branch_i=1 for 3 cycles, then hold_i=0 for 1 cycle → exactly one table step and branch_count_o +1.
- Async reset mid-run: after training entries and counts, pulse rst_i low for 1 ns between clock edges → all entries 10 and counts 0 immediately, before the next edge.
